// File: rtl/led_scanner.sv
// LED scanner: bounce, rotate, fill and hold patterns with a step prescaler.
// Lock forces every LED on and freezes the sweep state.
module led_scanner #(
  parameter int WIDTH = 10,
  parameter int SPAN  = 8,
  parameter int DIV   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lock,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         LED,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     dir,
  output logic                     wrap
);

  localparam int PW = $clog2(WIDTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SPAN - 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    BOUNCE = 2'b00,
    ROTATE = 2'b01,
    FILL   = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  mode_t          mode_q, mode_n;
  logic [CW-1:0]  count, count_n;
  logic [PW-1:0]  pos_n;
  logic           dir_n, wrap_n, step;
  logic [WIDTH-1:0] led_n;

  assign step = (count == CMAX) && !lock;

  always_comb begin
    pos_n   = pos;
    dir_n   = dir;
    count_n = count;
    mode_n  = mode_q;
    wrap_n  = 1'b0;
    if (reset) begin
      pos_n   = '0;
      dir_n   = 1'b0;
      count_n = '0;
      mode_n  = mode_t'(mode);
    end else if (lock) begin
      mode_n  = mode_q;
    end else if (mode_t'(mode) != mode_q) begin
      pos_n   = '0;
      dir_n   = 1'b0;
      count_n = '0;
      mode_n  = mode_t'(mode);
    end else begin
      count_n = step ? '0 : count + 1'b1;
      if (step) begin
        unique case (mode_q)
          BOUNCE: begin
            if (!dir) begin
              if (pos == LAST) begin
                pos_n = LAST - 1'b1;
                dir_n = 1'b1;
              end else begin
                pos_n = pos + 1'b1;
              end
            end else begin
              if (pos == '0) begin
                pos_n = PW'(1);
                dir_n = 1'b0;
              end else begin
                pos_n = pos - 1'b1;
              end
            end
            // a bounce step never moves 0 -> 0, so landing on 0 is a wrap
            wrap_n = (pos_n == '0);
          end
          ROTATE, FILL: begin
            pos_n  = (pos == LAST) ? '0 : pos + 1'b1;
            dir_n  = 1'b0;
            wrap_n = (pos == LAST);
          end
          HOLD: begin
            pos_n = pos;
          end
        endcase
      end
    end
  end

  always_comb begin
    led_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mode_n == FILL) led_n[i] = (i <= int'(pos_n));
      else                led_n[i] = (i == int'(pos_n));
    end
    if (lock && !reset) led_n = '1;
  end

  always_ff @(posedge clk) begin
    pos    <= pos_n;
    dir    <= dir_n;
    count  <= count_n;
    mode_q <= mode_n;
    wrap   <= wrap_n;
    LED    <= led_n;
  end

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner: three parameter sets share one stimulus
// stream; a phase-based reference model predicts every cycle's outputs.
module tb_led_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lock = 1'b0;
  logic [1:0] mode = 2'b00;

  logic [9:0] led_a, led_b;
  logic [1:0] led_c;
  logic [3:0] pos_a, pos_b;
  logic [0:0] pos_c;
  logic dir_a, dir_b, dir_c, wrap_a, wrap_b, wrap_c;

  led_scanner #(.WIDTH(10), .SPAN(8), .DIV(1)) u_a (
    .clk(clk), .reset(reset), .lock(lock), .mode(mode),
    .LED(led_a), .pos(pos_a), .dir(dir_a), .wrap(wrap_a));
  led_scanner #(.WIDTH(10), .SPAN(8), .DIV(4)) u_b (
    .clk(clk), .reset(reset), .lock(lock), .mode(mode),
    .LED(led_b), .pos(pos_b), .dir(dir_b), .wrap(wrap_b));
  led_scanner #(.WIDTH(2), .SPAN(2), .DIV(1)) u_c (
    .clk(clk), .reset(reset), .lock(lock), .mode(mode),
    .LED(led_c), .pos(pos_c), .dir(dir_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int wp[3] = '{10, 10, 2};
  int sp[3] = '{8, 8, 2};
  int dp[3] = '{1, 4, 1};

  // model state: sweep phase k, prescaler, mode, and "no step since restart"
  int k[3];
  int cnt[3];
  bit fresh[3];
  logic [1:0] mm[3];

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];

  task automatic model(input int i, input bit r, input bit l,
                       input logic [1:0] md);
    int w, s, d, per, ps;
    bit dr, wr, stp;
    logic [63:0] led, e;
    w = wp[i];
    s = sp[i];
    d = dp[i];
    wr = 1'b0;
    if (r) begin
      k[i] = 0; cnt[i] = 0; fresh[i] = 1'b1; mm[i] = md;
    end else if (l) begin
      wr = 1'b0;
    end else if (md != mm[i]) begin
      k[i] = 0; cnt[i] = 0; fresh[i] = 1'b1; mm[i] = md;
    end else begin
      stp = (cnt[i] == d - 1);
      cnt[i] = (cnt[i] + 1) % d;
      if (stp && mm[i] != 2'b11) begin
        per = (mm[i] == 2'b00) ? 2 * (s - 1) : s;
        k[i] = (k[i] + 1) % per;
        fresh[i] = 1'b0;
        wr = (k[i] == 0);
      end
    end
    if (mm[i] == 2'b00) begin
      ps = (k[i] < s) ? k[i] : 2 * (s - 1) - k[i];
      dr = (k[i] >= s) || (k[i] == 0 && !fresh[i]);
    end else begin
      ps = k[i];
      dr = 1'b0;
    end
    if (l && !r) led = (64'd1 << w) - 64'd1;
    else if (mm[i] == 2'b10) led = (64'd1 << (ps + 1)) - 64'd1;
    else led = 64'd1 << ps;
    e = {25'd0, led[31:0], 5'(ps), dr, wr};
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic cyc(input bit r, input bit l, input logic [1:0] md);
    @(negedge clk);
    reset = r;
    lock = l;
    mode = md;
    for (int i = 0; i < 3; i++) model(i, r, l, md);
  endtask

  task automatic chk(input int i, input logic [63:0] act);
    logic [63:0] e;
    bit have;
    have = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL dut%0d t=%0t led/pos/dir/wrap got %h/%0d/%0b/%0b want %h/%0d/%0b/%0b",
                 i, $time, act[38:7], act[6:2], act[1], act[0],
                 e[38:7], e[6:2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk(0, {25'd0, 22'd0, led_a, 1'b0, pos_a, dir_a, wrap_a});
      chk(1, {25'd0, 22'd0, led_b, 1'b0, pos_b, dir_b, wrap_b});
      chk(2, {25'd0, 30'd0, led_c, 4'd0, pos_c, dir_c, wrap_c});
    end
  end

  initial begin
    int lock_left;
    bit l;
    logic [1:0] md;
    cyc(1, 0, 2'b00);
    cyc(1, 0, 2'b00);
    repeat (40) cyc(0, 0, 2'b00);
    repeat (40) cyc(0, 0, 2'b01);
    repeat (20) cyc(0, 0, 2'b10);
    repeat (7) cyc(0, 1, 2'b10);
    repeat (20) cyc(0, 0, 2'b10);
    repeat (13) cyc(0, 0, 2'b00);
    cyc(0, 0, 2'b01);
    repeat (5) cyc(0, 0, 2'b01);
    cyc(0, 1, 2'b01);
    cyc(1, 1, 2'b01);
    cyc(1, 0, 2'b11);
    repeat (10) cyc(0, 0, 2'b11);
    cyc(1, 0, 2'b00);
    lock_left = 0;
    md = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      l = 1'b0;
      if (lock_left > 0) begin
        l = 1'b1;
        lock_left--;
      end else if ($urandom % 20 == 0) begin
        lock_left = $urandom_range(1, 9);
      end
      if ($urandom % 40 == 0) md = 2'($urandom);
      cyc(($urandom % 150) == 0, l, md);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of LED outputs (2..32).
REQ-002 SHALL have parameter SPAN, default 8, number of positions the pattern travels (2..WIDTH).
REQ-003 SHALL have parameter DIV, default 1, clk cycles per pattern step (1..65536).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port lock  input  1  high forces all LEDs on and freezes the pattern.
REQ-007 SHALL have port mode  input  2  00 bounce, 01 rotate, 10 fill, 11 hold.
REQ-008 SHALL have port LED  output  WIDTH  registered LED pattern.
REQ-009 SHALL have port pos  output  $clog2(WIDTH)  current position index 0..SPAN-1.
REQ-010 SHALL have port dir  output  1  0 = moving toward MSB, 1 = toward LSB; bounce mode only.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse at pattern end-of-sweep.

Function
REQ-012 SHALL contain a prescaler 0..DIV-1; step = (count == DIV-1) && !lock; count returns to 0 on step; DIV=1 steps every cycle.
REQ-013 SHALL hold pos, dir and prescaler unchanged while lock=1; prescaler does not advance while locked.
REQ-014 SHALL, in bounce mode on step: dir=0 and pos<SPAN-1 -> pos+1; dir=0 and pos=SPAN-1 -> pos=SPAN-2, dir=1; dir=1 and pos>0 -> pos-1; dir=1 and pos=0 -> pos=1, dir=0.
REQ-015 SHALL, in rotate mode on step: pos+1, with pos=SPAN-1 -> 0; dir forced 0.
REQ-016 SHALL, in fill mode on step: pos+1, with pos=SPAN-1 -> 0; dir forced 0.
REQ-017 SHALL, in hold mode, keep pos and dir constant regardless of step; prescaler keeps counting.
REQ-018 SHALL pulse wrap for exactly one cycle, coincident with the registered update: bounce when pos becomes 0; rotate/fill when pos changes SPAN-1 -> 0; never in hold or while locked.
REQ-019 SHALL register mode internally; when mode differs from the registered value (and reset=0), pos, dir and prescaler go to 0 that cycle, no step taken, wrap=0, LED updated accordingly.
REQ-020 SHALL drive LED one cycle after state: lock=1 -> all WIDTH bits 1; bounce/rotate/hold -> only bit pos set; fill -> bits 0..pos set (thermometer); bits SPAN..WIDTH-1 always 0 unless locked.
REQ-021 SHALL, on lock falling, resume from frozen pos/dir/prescaler; LED returns to the pattern the cycle after lock samples 0.
REQ-022 SHALL give a lock 1->0 then immediately-stepping prescaler at most one step on the first unlocked cycle (no catch-up of missed steps).
REQ-023 SHALL produce no X on any output after the first reset cycle for every legal parameter set.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, set pos=0, dir=0, prescaler=0, wrap=0, registered mode=mode input, LED=1 (bit 0 only).
REQ-025 SHALL give reset priority over lock, mode change and step, including mid-sweep and mid-lock.
REQ-026 SHALL hold reset values for every cycle reset stays asserted; normal stepping starts the first cycle after reset deasserts.

Verification
REQ-027 SHALL cover: WIDTH=10, SPAN=8, DIV=1, mode=00, 20 cycles -> LED walks 0x001..0x080..0x001; wrap pulses when pos returns to 0 (cycle 14); dir toggles at pos 7 and 0.
REQ-028 SHALL cover: DIV=4, mode=01 -> pos advances every 4th cycle 0..7, 7->0 raises wrap one cycle, LED=0x080 then 0x001.
REQ-029 SHALL cover: mode=10, SPAN=8 -> LED 0x001,0x003,...,0x0FF,0x001; wrap on the 0x0FF->0x001 transition.
REQ-030 SHALL cover: lock=1 at pos=5 for 7 cycles -> LED=0x3FF, pos stays 5, no wrap; lock=0 -> LED=0x020 next cycle, stepping resumes.
REQ-031 SHALL cover: mode 00->01 at pos=6, dir=1 -> pos=0, dir=0, LED=0x001 next cycle; reset asserted together with lock=1 -> LED=0x001, pos=0.
REQ-032 SHALL cover: SPAN=2, WIDTH=2, bounce -> pos alternates 0,1,0,1; wrap on every return to 0; LED alternates 0x1,0x2.
